// File: rtl/fetch_sequencer_if.sv
// Bundle of PC-control, instruction-memory, decode and execute signals
// exchanged between fetch_sequencer (master) and its environment (slave).
`ifndef FETCH_SEQUENCER_DEFS
`define FETCH_SEQUENCER_DEFS
`define XBUS [31:0]
`define PC_MODE_MSB 1
`define PC_MODE_INC 2'd0
`define PC_MODE_ADD 2'd1
`define PC_MODE_SET 2'd2
`endif

interface fetch_sequencer_if;
   // program counter control
   logic `XBUS              pc_current;
   logic [`PC_MODE_MSB:0]   pc_mode;
   logic `XBUS              pc_update;
   logic                    pc_update_en;
   // instruction memory read
   logic                    imem_req;
   logic `XBUS              imem_addr;
   logic                    imem_ack;
   logic `XBUS              imem_rdata;
   // decode handshake
   logic `XBUS              instr;
   logic                    instr_valid;
   logic                    instr_ready;
   // execute completion and redirects
   logic                    exec_done;
   logic                    br_taken;
   logic `XBUS              br_offset;
   logic                    jmp_taken;
   logic `XBUS              jmp_target;
   logic                    trap;
   logic [31:0]             instret;

   modport master (
      input  pc_current, imem_ack, imem_rdata, instr_ready,
             exec_done, br_taken, br_offset, jmp_taken, jmp_target, trap,
      output pc_mode, pc_update, pc_update_en, imem_req, imem_addr,
             instr, instr_valid, instret
   );

   modport slave (
      output pc_current, imem_ack, imem_rdata, instr_ready,
             exec_done, br_taken, br_offset, jmp_taken, jmp_target, trap,
      input  pc_mode, pc_update, pc_update_en, imem_req, imem_addr,
             instr, instr_valid, instret
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: drives the PC control inputs, fetches the word at
// the current PC, hands it to decode, waits for execute and picks the next PC
// (trap > jump > branch > increment). The PC itself has no reset, so reset is
// forwarded combinationally as a SET of the reset vector.
`ifndef FETCH_SEQUENCER_DEFS
`define FETCH_SEQUENCER_DEFS
`define XBUS [31:0]
`define PC_MODE_MSB 1
`define PC_MODE_INC 2'd0
`define PC_MODE_ADD 2'd1
`define PC_MODE_SET 2'd2
`endif

module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master bus
);

   // targets and offsets are forced to word alignment
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_EXEC  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic `XBUS            instr_q, instr_d;
   logic                  instr_valid_q, instr_valid_d;
   logic [31:0]           instret_q, instret_d;

   logic                  fetch_c;
   logic                  retire_c;
   logic [`PC_MODE_MSB:0] pc_mode_c;
   logic `XBUS            pc_update_c;
   logic                  pc_update_en_c;

   // State, held instruction and retire counter; reset is synchronous
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_INIT;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         instret_q     <= '0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         instret_q     <= instret_d;
      end
   end

   // Sequencing: each handshake input is only looked at in its own state
   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      instret_d     = instret_q;
      fetch_c       = 1'b0;
      retire_c      = 1'b0;
      case (state_q)
         S_INIT: begin
            // one settle cycle so the freshly loaded PC is visible to FETCH
            state_d = S_FETCH;
         end
         S_FETCH: begin
            fetch_c = 1'b1;
            if (bus.imem_ack) begin
               instr_d       = bus.imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = S_EXEC;
            end
         end
         S_EXEC: begin
            if (bus.exec_done) begin
               retire_c  = 1'b1;
               instret_d = instret_q + 32'd1;
               state_d   = S_FETCH;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // PC control: reset vector while in reset, otherwise redirect on retire
   always_comb begin
      pc_mode_c      = `PC_MODE_INC;
      pc_update_c    = '0;
      pc_update_en_c = 1'b0;
      if (reset) begin
         pc_mode_c      = `PC_MODE_SET;
         pc_update_c    = RESET_VECTOR;
         pc_update_en_c = 1'b1;
      end else if (retire_c) begin
         pc_update_en_c = 1'b1;
         if (bus.trap) begin
            pc_mode_c   = `PC_MODE_SET;
            pc_update_c = TRAP_VECTOR;
         end else if (bus.jmp_taken) begin
            pc_mode_c   = `PC_MODE_SET;
            pc_update_c = bus.jmp_target & ALIGN_MASK;
         end else if (bus.br_taken) begin
            pc_mode_c   = `PC_MODE_ADD;
            pc_update_c = bus.br_offset & ALIGN_MASK;
         end
      end
   end

   assign bus.pc_mode      = pc_mode_c;
   assign bus.pc_update    = pc_update_c;
   assign bus.pc_update_en = pc_update_en_c;
   assign bus.imem_req     = fetch_c & ~reset;
   assign bus.imem_addr    = bus.pc_current;
   assign bus.instr        = instr_q;
   assign bus.instr_valid  = instr_valid_q;
   assign bus.instret      = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a bench-side PC follows the DUT's PC controls,
// a transaction-level model predicts fetch addresses, held instruction,
// retire count and PC controls, and a negedge process compares every cycle.
module tb_fetch_sequencer;

   localparam logic [1:0]  MODE_INC = 2'd0;
   localparam logic [1:0]  MODE_ADD = 2'd1;
   localparam logic [1:0]  MODE_SET = 2'd2;
   localparam logic [31:0] RV       = 32'h0000_0000;
   localparam logic [31:0] TV       = 32'h0000_0010;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_sequencer_if bus();

   fetch_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void chk1(string name, logic act, logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Program counter owned by the environment; it obeys the DUT's controls
   logic [31:0] pc_q;
   assign bus.pc_current = pc_q;
   always @(posedge clk) begin
      if (bus.pc_update_en === 1'b1) begin
         case (bus.pc_mode)
            MODE_INC: pc_q <= pc_q + 32'd4;
            MODE_ADD: pc_q <= pc_q + bus.pc_update;
            MODE_SET: pc_q <= bus.pc_update;
            default:  pc_q <= 'x;
         endcase
      end
   end

   // ---------------- reference model ----------------
   typedef enum {M_SETTLE, M_FETCH, M_DECODE, M_EXEC} mstage_t;
   mstage_t     m_st;
   logic [31:0] m_pc, m_instr, m_ret;
   logic        m_valid;
   bit          m_live = 1'b0;

   function automatic logic [31:0] model_next_pc(logic [31:0] pc);
      if (bus.trap)           return TV;
      else if (bus.jmp_taken) return {bus.jmp_target[31:2], 2'b00};
      else if (bus.br_taken)  return pc + {bus.br_offset[31:2], 2'b00};
      else                    return pc + 32'd4;
   endfunction

   function automatic logic model_retiring();
      return !reset && m_st == M_EXEC && bus.exec_done;
   endfunction

   function automatic logic [1:0] model_mode();
      if (reset) return MODE_SET;
      if (!model_retiring()) return MODE_INC;
      if (bus.trap || bus.jmp_taken) return MODE_SET;
      return bus.br_taken ? MODE_ADD : MODE_INC;
   endfunction

   function automatic logic [31:0] model_update();
      if (reset) return RV;
      if (!model_retiring()) return 32'd0;
      if (bus.trap) return TV;
      if (bus.jmp_taken) return {bus.jmp_target[31:2], 2'b00};
      if (bus.br_taken) return {bus.br_offset[31:2], 2'b00};
      return 32'd0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_live  <= 1'b1;
         m_st    <= M_SETTLE;
         m_pc    <= RV;
         m_instr <= 32'd0;
         m_valid <= 1'b0;
         m_ret   <= 32'd0;
      end else if (m_live) begin
         case (m_st)
            M_SETTLE: m_st <= M_FETCH;
            M_FETCH: if (bus.imem_ack) begin
               m_instr <= bus.imem_rdata;
               m_valid <= 1'b1;
               m_st    <= M_DECODE;
            end
            M_DECODE: if (bus.instr_ready) begin
               m_valid <= 1'b0;
               m_st    <= M_EXEC;
            end
            M_EXEC: if (bus.exec_done) begin
               m_pc  <= model_next_pc(m_pc);
               m_ret <= m_ret + 32'd1;
               m_st  <= M_FETCH;
            end
            default: m_st <= M_SETTLE;
         endcase
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_live) begin
         chk1("imem_req", bus.imem_req, !reset && m_st == M_FETCH);
         if (!reset && m_st == M_FETCH) chk("imem_addr", bus.imem_addr, m_pc);
         chk1("pc_update_en", bus.pc_update_en, reset || model_retiring());
         chk("pc_mode", {30'd0, bus.pc_mode}, {30'd0, model_mode()});
         chk("pc_update", bus.pc_update, model_update());
         chk1("instr_valid", bus.instr_valid, m_valid);
         chk("instr", bus.instr, m_instr);
         chk("instret", bus.instret, m_ret);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 32'd0;
      bus.instr_ready = 1'b0;
      bus.exec_done   = 1'b0;
      bus.br_taken    = 1'b0;
      bus.br_offset   = 32'd0;
      bus.jmp_taken   = 1'b0;
      bus.jmp_target  = 32'd0;
      bus.trap        = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   // One instruction from FETCH: ack after ack_dly, ready after rdy_dly
   // (exec_done/trap pulsed meanwhile and must be ignored), done after done_dly.
   task automatic run_instr(input int ack_dly, input logic [31:0] rdata,
                            input int rdy_dly, input int done_dly,
                            input logic tr, input logic jp, input logic [31:0] tgt,
                            input logic br, input logic [31:0] off,
                            output int req_cyc, output logic [31:0] seen);
      req_cyc = 0;
      chk1("fetch_start", bus.imem_req, 1'b1);
      repeat (ack_dly) begin
         if (bus.imem_req === 1'b1) req_cyc++;
         step();
      end
      if (bus.imem_req === 1'b1) req_cyc++;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = rdata;
      step();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      repeat (rdy_dly) begin
         bus.exec_done = 1'b1;
         bus.trap      = 1'b1;
         #1;
         chk1("issue_hold_valid", bus.instr_valid, 1'b1);
         chk("issue_hold_instr", bus.instr, rdata);
         step();
      end
      bus.exec_done   = 1'b0;
      bus.trap        = 1'b0;
      bus.instr_ready = 1'b1;
      seen            = bus.instr;
      step();
      bus.instr_ready = 1'b0;
      repeat (done_dly) step();
      bus.trap       = tr;
      bus.jmp_taken  = jp;
      bus.jmp_target = tgt;
      bus.br_taken   = br;
      bus.br_offset  = off;
      bus.exec_done  = 1'b1;
      step();
      idle_inputs();
   endtask

   logic [31:0] a_q[$];
   int          c_q[$];
   int          rc;
   logic [31:0] seen;

   initial begin
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      // reset forces the PC load combinationally
      chk("rst_mode", {30'd0, bus.pc_mode}, 32'd2);
      chk("rst_update", bus.pc_update, 32'h0);
      chk1("rst_en", bus.pc_update_en, 1'b1);
      chk1("rst_req", bus.imem_req, 1'b0);
      chk("rst_instret", bus.instret, 32'd0);
      chk1("rst_valid", bus.instr_valid, 1'b0);

      // INIT cycle, then back-to-back instructions at the 3-cycle minimum
      reset = 1'b0;
      #1;
      chk1("init_req", bus.imem_req, 1'b0);
      chk1("init_en", bus.pc_update_en, 1'b0);
      bus.imem_ack    = 1'b1;
      bus.instr_ready = 1'b1;
      bus.exec_done   = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         if (bus.imem_req === 1'b1) begin
            a_q.push_back(bus.imem_addr);
            c_q.push_back(c);
         end
      end
      step();
      idle_inputs();
      chk("seq_count", a_q.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("seq_addr", (i < a_q.size()) ? a_q[i] : 32'hxxxx_xxxx, 32'(i * 4));
         chk("seq_cycle", (i < c_q.size()) ? 32'(c_q[i]) : 32'hxxxx_xxxx, 32'(1 + i * 3));
      end
      chk("seq_instret", bus.instret, 32'd3);
      chk("seq_next_addr", bus.imem_addr, 32'hC);

      // directed redirects
      do_reset();
      step();
      run_instr(0, 32'h1111_0000, 0, 0, 0, 0, 0, 0, 0, rc, seen);
      run_instr(1, 32'h2222_0000, 0, 1, 0, 0, 0, 0, 0, rc, seen);
      chk("at_pc8", bus.imem_addr, 32'h8);
      run_instr(4, 32'hDEAD_BEEF, 3, 0, 0, 1, 32'h20, 0, 0, rc, seen);
      chk("ack_wait_req_cycles", rc, 32'd5);
      chk("ack_wait_instr", seen, 32'hDEAD_BEEF);
      chk("jmp_to_20", bus.imem_addr, 32'h20);
      run_instr(0, 32'h3, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF0, rc, seen);
      chk("branch_back", bus.imem_addr, 32'h10);
      run_instr(0, 32'h4, 0, 0, 0, 1, 32'h127, 0, 0, rc, seen);
      chk("jmp_misaligned", bus.imem_addr, 32'h124);
      run_instr(0, 32'h5, 0, 0, 0, 1, 32'h40, 0, 0, rc, seen);
      chk("jmp_to_40", bus.imem_addr, 32'h40);
      chk("instret_before_trap", bus.instret, 32'd6);
      run_instr(2, 32'h6, 1, 2, 1, 1, 32'h80, 1, 32'h100, rc, seen);
      chk("trap_priority", bus.imem_addr, 32'h10);
      chk("trap_instret", bus.instret, 32'd7);

      // reset mid-fetch with a late ack
      reset = 1'b1;
      #1;
      chk1("midrst_req", bus.imem_req, 1'b0);
      chk1("midrst_en", bus.pc_update_en, 1'b1);
      chk("midrst_update", bus.pc_update, 32'h0);
      step();
      reset          = 1'b0;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h0000_1234;
      #1;
      chk1("midrst_init_req", bus.imem_req, 1'b0);
      step();
      bus.imem_ack = 1'b0;
      chk1("midrst_fetch_req", bus.imem_req, 1'b1);
      chk("midrst_addr", bus.imem_addr, 32'h0);
      chk1("midrst_ack_ignored", bus.instr_valid, 1'b0);
      chk("midrst_instret", bus.instret, 32'd0);
      step();

      // randomized traffic, occasional reset
      for (int i = 0; i < 4000; i++) begin
         reset           = ($urandom_range(99) == 0);
         bus.imem_ack    = 1'($urandom_range(1));
         bus.imem_rdata  = $urandom;
         bus.instr_ready = 1'($urandom_range(1));
         bus.exec_done   = ($urandom_range(2) == 0);
         bus.trap        = ($urandom_range(5) == 0);
         bus.jmp_taken   = ($urandom_range(3) == 0);
         bus.br_taken    = ($urandom_range(2) == 0);
         bus.jmp_target  = $urandom;
         bus.br_offset   = $urandom;
         step();
      end
      reset = 1'b0;
      idle_inputs();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
